latch_snapshot_reader: RTL and testbench

LATCH_SNAPSHOT_READER -- requirements
Module: latch_snapshot_reader

---
 rtl/latch_snapshot_reader.sv | 170 +++++++++++++++++
 tb/tb_latch_snapshot_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_snapshot_reader.sv
// -----------------------------------------------------------------------------
// latch_snapshot_reader
//
// Takes a coherent snapshot of a downstream transparent latch. On a request
// the latch is closed (latch_en low), the block waits SETTLE cycles for the
// latch output to settle, captures the word into out_data and presents it
// with a valid/ready handshake. Once the consumer accepts it, the latch is
// reopened and the accepted-snapshot counter advances.
//
// Handshake rule: a transfer happens at a rising clk edge where out_valid=1
// and out_ready=1. out_valid never drops and out_data never changes until that
// transfer, and out_ready has no effect while out_valid=0.
//
// Parameters
//   WIDTH   width of latch_q / out_data
//   SETTLE  cycles from closing the latch to sampling it (legal 1..255)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   snap_req    level-sampled snapshot request (ignored while busy)
//   latch_en    registered latch enable, 1 = transparent, 0 = hold
//   latch_q     latch output word
//   out_data    captured snapshot word (holds until the next capture)
//   out_valid   out_data holds an unconsumed snapshot
//   out_ready   consumer accepts out_data
//   busy        combinational, high whenever the FSM is not idle
//   snap_count  number of snapshots accepted by the consumer (wraps)
//   dbg_state   current FSM state: 0 = IDLE, 1 = CLOSE, 2 = PRESENT
// -----------------------------------------------------------------------------
module latch_snapshot_reader #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snap_req,
  output logic             latch_en,
  input  logic [WIDTH-1:0] latch_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      snap_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLOSE   = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Settle counter value at which the latch output is sampled.
  localparam logic [7:0] LP_LAST_CNT = 8'(SETTLE - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_settle_cnt;
  logic               r_latch_en;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;
  logic [15:0]        r_snap_count;

  logic               w_start;
  logic               w_capture;
  logic               w_handshake;

  assign w_start     = (r_state == ST_IDLE) && snap_req;
  assign w_capture   = (r_state == ST_CLOSE) && (r_settle_cnt == LP_LAST_CNT);
  assign w_handshake = (r_state == ST_PRESENT) && r_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        if (w_capture) begin
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (w_handshake) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered datapath: latch enable, settle counter, snapshot word/valid
  // and the accepted-snapshot counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle_cnt <= 8'd0;
      r_latch_en   <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_snap_count <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (snap_req) begin
            r_settle_cnt <= 8'd0;
            r_latch_en   <= 1'b0;
          end else begin
            r_latch_en   <= 1'b1;
          end
        end
        ST_CLOSE: begin
          r_latch_en   <= 1'b0;
          r_settle_cnt <= r_settle_cnt + 8'd1;
          // latch_q is only ever looked at on this edge.
          if (w_capture) begin
            r_out_data  <= latch_q;
            r_out_valid <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (w_handshake) begin
            r_out_valid  <= 1'b0;
            r_snap_count <= r_snap_count + 16'd1;
            // With a request already pending the latch stays closed, so a
            // back-to-back snapshot never sees a one-cycle reopen glitch.
            r_latch_en   <= ~snap_req;
          end
        end
        default: begin
          r_latch_en <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (r_state != ST_IDLE);
    dbg_state = r_state;
  end

  assign latch_en   = r_latch_en;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign snap_count = r_snap_count;

endmodule

// File: tb/tb_latch_snapshot_reader.sv
// -----------------------------------------------------------------------------
// Bench for latch_snapshot_reader. Two instances share the same stimulus:
// dut0 with SETTLE=2 and dut1 with SETTLE=1. A behavioural model of each
// (request -> close, capture SETTLE edges later, hold until accepted) is
// compared against the outputs on every falling edge, and directed phases add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_latch_snapshot_reader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        snap_req;
  logic        out_ready;
  logic [31:0] latch_q;

  logic        len0, val0, busy0;
  logic [31:0] data0;
  logic [15:0] cnt0;
  logic [1:0]  st0;
  logic        len1, val1, busy1;
  logic [31:0] data1;
  logic [15:0] cnt1;
  logic [1:0]  st1;

  latch_snapshot_reader #(.WIDTH(32), .SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .snap_req(snap_req), .latch_en(len0),
    .latch_q(latch_q), .out_data(data0), .out_valid(val0),
    .out_ready(out_ready), .busy(busy0), .snap_count(cnt0), .dbg_state(st0)
  );

  latch_snapshot_reader #(.WIDTH(32), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .snap_req(snap_req), .latch_en(len1),
    .latch_q(latch_q), .out_data(data1), .out_valid(val1),
    .out_ready(out_ready), .busy(busy1), .snap_count(cnt1), .dbg_state(st1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a snapshot in flight counts down the edges left before
  // capture; once captured it waits for acceptance.
  // ---------------------------------------------------------------------------
  int          m_settle [2] = '{2, 1};
  logic        m_busy   [2];
  logic        m_valid  [2];
  logic        m_len    [2];
  int          m_left   [2];
  logic [31:0] m_data   [2];
  logic [15:0] m_cnt    [2];
  logic        preload = 1'b0;
  logic        chk_en  = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preload) m_cnt[i] = 16'hFFFF;
      if (rst) begin
        m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_len[i] = 1'b0;
        m_left[i] = 0;    m_data[i]  = 32'd0; m_cnt[i] = 16'd0;
      end else if (!m_busy[i]) begin
        if (snap_req) begin
          m_busy[i] = 1'b1; m_left[i] = m_settle[i]; m_len[i] = 1'b0;
        end else begin
          m_len[i] = 1'b1;
        end
      end else if (!m_valid[i]) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_valid[i] = 1'b1; m_data[i] = latch_q;
        end
      end else if (out_ready) begin
        m_valid[i] = 1'b0; m_busy[i] = 1'b0;
        m_cnt[i]   = m_cnt[i] + 16'd1;
        m_len[i]   = ~snap_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge once reset has been applied
  // ---------------------------------------------------------------------------
  task automatic cmp_inst(input int i, input logic len, input logic val, input logic [31:0] data,
                          input logic bsy, input logic [15:0] cnt);
    check($sformatf("dut%0d latch_en", i),   {31'd0, len}, {31'd0, m_len[i]});
    check($sformatf("dut%0d out_valid", i),  {31'd0, val}, {31'd0, m_valid[i]});
    check($sformatf("dut%0d out_data", i),   data, m_data[i]);
    check($sformatf("dut%0d busy", i),       {31'd0, bsy}, {31'd0, m_busy[i]});
    check($sformatf("dut%0d snap_count", i), {16'd0, cnt}, {16'd0, m_cnt[i]});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, len0, val0, data0, busy0, cnt0);
      cmp_inst(1, len1, val1, data1, busy1, cnt1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] base0, base1;

  initial begin
    rst = 1'b1; snap_req = 1'b0; out_ready = 1'b0; latch_q = 32'd0;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst latch_en", {31'd0, len0}, 32'd0);
    check("rst out_valid", {31'd0, val0}, 32'd0);
    check("rst snap_count", {16'd0, cnt0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release latch_en", {31'd0, len0}, 32'd1);

    // Basic snapshot
    latch_q = 32'hDEADBEEF; out_ready = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    check("basic latch closed", {31'd0, len0}, 32'd0);
    @(negedge clk);
    check("basic not yet valid", {31'd0, val0}, 32'd0);
    @(negedge clk);
    check("basic valid", {31'd0, val0}, 32'd1);
    check("basic data", data0, 32'hDEADBEEF);
    @(negedge clk);
    check("basic one-cycle valid", {31'd0, val0}, 32'd0);
    check("basic reopen", {31'd0, len0}, 32'd1);
    check("basic count", {16'd0, cnt0}, 32'd1);

    // Backpressure
    out_ready = 1'b0; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (2) @(negedge clk);
    check("bp valid", {31'd0, val0}, 32'd1);
    latch_q = 32'h12345678;
    for (int k = 0; k < 10; k++) begin
      snap_req = (k == 3);
      @(negedge clk);
      check("bp data held", data0, 32'hDEADBEEF);
      check("bp latch held", {31'd0, len0}, 32'd0);
    end
    snap_req = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp count", {16'd0, cnt0}, 32'd2);
    check("bp count dut1", {16'd0, cnt1}, 32'd2);
    @(negedge clk);
    check("bp data kept", data0, 32'hDEADBEEF);

    // Back-to-back with request held high
    base0 = cnt0; base1 = cnt1;
    snap_req = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      latch_q = $urandom;
      @(negedge clk);
      check("b2b latch_en dut0", {31'd0, len0}, 32'd0);
      check("b2b latch_en dut1", {31'd0, len1}, 32'd0);
    end
    check("b2b count dut1", {16'd0, 16'(cnt1 - base1)}, 32'd10);
    check("b2b count dut0", {16'd0, 16'(cnt0 - base0)}, 32'd7);
    snap_req = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      snap_req  = ($urandom_range(0, 2) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      latch_q   = $urandom;
      @(negedge clk);
    end
    rst = 1'b0; snap_req = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // Abort mid-CLOSE
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort no valid dut0", {31'd0, val0}, 32'd0);
      check("abort no valid dut1", {31'd0, val1}, 32'd0);
      check("abort count", {16'd0, cnt0}, 32'd0);
    end

    // Counter wrap: preload 0xFFFF then one more handshake
    #2;
    force dut0.r_snap_count = 16'hFFFF;
    force dut1.r_snap_count = 16'hFFFF;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    #2;
    release dut0.r_snap_count;
    release dut1.r_snap_count;
    @(negedge clk);
    check("wrap preload", {16'd0, cnt0}, 32'h0000FFFF);
    snap_req = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (3) @(negedge clk);
    check("wrap dut0", {16'd0, cnt0}, 32'd0);
    check("wrap dut1", {16'd0, cnt1}, 32'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
